// File: rtl/sha_mem_pkg.sv
// Shared constants, tag type and round-robin helper for the SHA-core SDRAM arbiter.
package sha_mem_pkg;

  localparam int N_REQ    = 10;
  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_PEND = 8;
  localparam int TAG_W    = $clog2(N_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic found;
    tag_t idx;
  } pick_t;

  // First set bit of req_vec at or above ptr, wrapping past N_REQ-1 back to 0.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req_vec, input tag_t ptr);
    pick_t          res;
    logic [TAG_W:0] sum;
    tag_t           cand;
    res = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (TAG_W+1)'(k);
      if (sum >= (TAG_W+1)'(N_REQ))
        sum = sum - (TAG_W+1)'(N_REQ);
      cand = sum[TAG_W-1:0];
      if (!res.found && req_vec[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sha_sdram_arbiter_if.sv
// Avalon-MM style bus bundle; N>1 carries one slice per requester, N=1 is a plain master link.
interface sha_sdram_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic [N*ADDR_W-1:0]     address;
  logic [N-1:0]            read;
  logic [N-1:0]            write;
  logic [N*DATA_W-1:0]     writedata;
  logic [N*(DATA_W/8)-1:0] byteenable;
  logic [N-1:0]            waitrequest;
  logic [DATA_W-1:0]       readdata;
  logic [N-1:0]            readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sha_arb_tag_fifo.sv
// Tag FIFO remembering which requester issued each outstanding read, in issue order.
module sha_arb_tag_fifo
  import sha_mem_pkg::*;
#(
  parameter int DEPTH = MAX_PEND
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  tag_t din,
  output logic full,
  output logic empty,
  output tag_t head
);

  localparam int PTR_W = $clog2(DEPTH);

  tag_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still fine when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sha_sdram_arbiter.sv
// Round-robin sharing of one SDRAM Avalon-MM slave among the SHA cores, with
// read data steered back to its issuer through a tag FIFO.
module sha_sdram_arbiter
  import sha_mem_pkg::*;
(
  input  logic                sys_clk_clk,
  input  logic                reset_reset,
  sha_sdram_arbiter_if.slave  req,
  sha_sdram_arbiter_if.master avm,
  output logic                err_unexpected_rdv
);

  tag_t             rr_ptr;
  tag_t             locked_idx;
  logic             lock;
  tag_t             gnt;
  pick_t            pick;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant_onehot;
  logic             gnt_write;
  logic             gnt_read;
  logic             cmd_valid;
  logic             accept;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  tag_t             fifo_head;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] wdata_arr[N_REQ];
  logic [BE_W-1:0]   be_arr   [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign addr_arr[i]  = req.address[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req.writedata[i*DATA_W +: DATA_W];
    assign be_arr[i]    = req.byteenable[i*BE_W +: BE_W];
  end

  // A stalled command holds the grant so the Avalon command stays stable until accepted.
  always_comb begin
    eligible  = req.write | (req.read & {N_REQ{~fifo_full}});
    pick      = rr_pick(eligible, rr_ptr);
    gnt       = lock ? locked_idx : pick.idx;
    gnt_write = req.write[gnt];
    gnt_read  = req.read[gnt] & ~gnt_write;
    cmd_valid = ~reset_reset & (lock | pick.found) & (gnt_write | gnt_read);
    accept    = cmd_valid & ~avm.waitrequest[0];
  end

  assign grant_onehot      = N_REQ'(1) << gnt;
  assign avm.address       = addr_arr[gnt];
  assign avm.writedata     = wdata_arr[gnt];
  assign avm.byteenable    = be_arr[gnt];
  assign avm.read          = cmd_valid & gnt_read;
  assign avm.write         = cmd_valid & gnt_write;
  assign req.waitrequest   = ~(grant_onehot & {N_REQ{accept}});
  assign req.readdata      = avm.readdata;
  assign fifo_push         = accept & gnt_read;
  assign fifo_pop          = avm.readdatavalid[0] & ~fifo_empty;
  assign req.readdatavalid = fifo_pop ? (N_REQ'(1) << fifo_head) : '0;

  always_ff @(posedge sys_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rr_ptr             <= '0;
      lock               <= 1'b0;
      locked_idx         <= '0;
      err_unexpected_rdv <= 1'b0;
    end else begin
      if (accept) begin
        lock   <= 1'b0;
        rr_ptr <= (gnt == tag_t'(N_REQ-1)) ? '0 : gnt + 1'b1;
      end else if (cmd_valid) begin
        lock       <= 1'b1;
        locked_idx <= gnt;
      end
      if (avm.readdatavalid[0] & fifo_empty)
        err_unexpected_rdv <= 1'b1;
    end
  end

  sha_arb_tag_fifo #(.DEPTH(MAX_PEND)) u_tag_fifo (
    .clk   (sys_clk_clk),
    .rst   (reset_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (gnt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_sha_sdram_arbiter.sv
// Directed self-checking bench for sha_sdram_arbiter: reset, fairness, lock, FIFO full, ordering, error.
module tb_sha_sdram_arbiter;
  import sha_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic err;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  always #5 clk = ~clk;

  sha_sdram_arbiter_if #(.N(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_bus ();
  sha_sdram_arbiter_if #(.N(1),     .ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm_bus ();

  sha_sdram_arbiter dut (
    .sys_clk_clk        (clk),
    .reset_reset        (rst),
    .req                (req_bus),
    .avm                (avm_bus),
    .err_unexpected_rdv (err)
  );

  localparam logic [N_REQ-1:0] ALL_WAIT = '1;

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_bus.read              = '0;
    req_bus.write             = '0;
    avm_bus.waitrequest       = 1'b0;
    avm_bus.readdatavalid     = 1'b0;
    avm_bus.readdata          = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < N_REQ; i++) begin
      req_bus.address[i*ADDR_W +: ADDR_W]  = ADDR_W'(100 + i);
      req_bus.writedata[i*DATA_W +: DATA_W] = 32'hD000_0000 + 32'(i);
      req_bus.byteenable[i*BE_W +: BE_W]    = '1;
    end
    req_bus.read = '1;
    #12;
    check("reset_avm_read", 64'(avm_bus.read), 64'd0);
    check("reset_wait", 64'(req_bus.waitrequest), 64'(ALL_WAIT));
    check("reset_err", 64'(err), 64'd0);
    check("reset_rdv", 64'(req_bus.readdatavalid), 64'd0);

    next_cycle();
    rst = 1'b0;

    // Fairness: everybody reads, data returns one cycle after each accept.
    for (int k = 0; k < 12; k++) begin
      if (k > 0) next_cycle();
      req_bus.read          = (k <= 10) ? '1 : '0;
      avm_bus.readdatavalid = (k >= 1);
      avm_bus.readdata      = 32'hA000_0000 + 32'(k);
      #1;
      if (k <= 10) begin
        check($sformatf("rr_addr_%0d", k), 64'(avm_bus.address), 64'(100 + (k % 10)));
        check($sformatf("rr_wait_%0d", k), 64'(req_bus.waitrequest), 64'(ALL_WAIT & ~onehot(k % 10)));
      end
      if (k >= 1) begin
        check($sformatf("rr_rdv_%0d", k), 64'(req_bus.readdatavalid), 64'(onehot((k - 1) % 10)));
        check($sformatf("rr_rdata_%0d", k), 64'(req_bus.readdata), 64'(32'hA000_0000 + 32'(k)));
      end
    end

    // Stall/lock: req 3 stalled 4 cycles; req 2 arriving mid-stall must not steal the grant.
    for (int s = 0; s < 5; s++) begin
      next_cycle();
      idle();
      req_bus.write[3]    = 1'b1;
      req_bus.write[5]    = 1'b1;
      req_bus.write[2]    = (s >= 2);
      avm_bus.waitrequest = (s < 4);
      #1;
      check($sformatf("lock_addr_%0d", s), 64'(avm_bus.address), 64'd103);
      check($sformatf("lock_write_%0d", s), 64'(avm_bus.write), 64'd1);
      check($sformatf("lock_wait_%0d", s), 64'(req_bus.waitrequest),
            (s < 4) ? 64'(ALL_WAIT) : 64'(ALL_WAIT & ~onehot(3)));
    end
    check("lock_wdata", 64'(avm_bus.writedata), 64'h0000_0000_D000_0003);
    next_cycle();
    req_bus.write[3] = 1'b0;
    #1;
    check("after_lock_addr5", 64'(avm_bus.address), 64'd105);
    check("after_lock_wait5", 64'(req_bus.waitrequest), 64'(ALL_WAIT & ~onehot(5)));
    next_cycle();
    req_bus.write[5] = 1'b0;
    #1;
    check("after_lock_addr2", 64'(avm_bus.address), 64'd102);
    next_cycle();
    idle();

    // FIFO full: eight back-to-back reads from req 6 with no data returned.
    for (int i = 0; i < 8; i++) begin
      req_bus.read[6] = 1'b1;
      #1;
      check($sformatf("fill_addr_%0d", i), 64'(avm_bus.address), 64'd106);
      check($sformatf("fill_wait_%0d", i), 64'(req_bus.waitrequest), 64'(ALL_WAIT & ~onehot(6)));
      next_cycle();
    end
    req_bus.read[6]  = 1'b0;
    req_bus.read[2]  = 1'b1;
    req_bus.write[4] = 1'b1;
    #1;
    check("full_write_addr", 64'(avm_bus.address), 64'd104);
    check("full_write", 64'(avm_bus.write), 64'd1);
    check("full_read_held", 64'(avm_bus.read), 64'd0);
    check("full_wait", 64'(req_bus.waitrequest), 64'(ALL_WAIT & ~onehot(4)));
    next_cycle();
    req_bus.write[4] = 1'b0;
    #1;
    check("full_no_read", 64'(avm_bus.read), 64'd0);
    check("full_all_wait", 64'(req_bus.waitrequest), 64'(ALL_WAIT));
    next_cycle();
    avm_bus.readdatavalid = 1'b1;
    avm_bus.readdata      = 32'h0000_0055;
    #1;
    check("full_pop_rdv", 64'(req_bus.readdatavalid), 64'(onehot(6)));
    check("full_pop_still_held", 64'(avm_bus.read), 64'd0);
    next_cycle();
    avm_bus.readdatavalid = 1'b0;
    #1;
    check("freed_read", 64'(avm_bus.read), 64'd1);
    check("freed_addr", 64'(avm_bus.address), 64'd102);
    check("freed_wait", 64'(req_bus.waitrequest), 64'(ALL_WAIT & ~onehot(2)));
    next_cycle();
    req_bus.read[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      avm_bus.readdatavalid = 1'b1;
      #1;
      check($sformatf("drain_rdv_%0d", i), 64'(req_bus.readdatavalid),
            (i < 7) ? 64'(onehot(6)) : 64'(onehot(2)));
      next_cycle();
    end
    avm_bus.readdatavalid = 1'b0;

    // Ordering: reads 7, 1, 7 then three data beats.
    req_bus.read[7] = 1'b1;
    #1;
    check("ord_addr_a", 64'(avm_bus.address), 64'd107);
    next_cycle();
    req_bus.read[7] = 1'b0;
    req_bus.read[1] = 1'b1;
    #1;
    check("ord_addr_b", 64'(avm_bus.address), 64'd101);
    next_cycle();
    req_bus.read[1] = 1'b0;
    req_bus.read[7] = 1'b1;
    #1;
    check("ord_addr_c", 64'(avm_bus.address), 64'd107);
    next_cycle();
    req_bus.read[7]       = 1'b0;
    avm_bus.readdatavalid = 1'b1;
    avm_bus.readdata      = 32'h0000_000A;
    #1;
    check("ord_rdv_a", 64'(req_bus.readdatavalid), 64'h080);
    check("ord_data_a", 64'(req_bus.readdata), 64'h00A);
    next_cycle();
    avm_bus.readdata = 32'h0000_000B;
    #1;
    check("ord_rdv_b", 64'(req_bus.readdatavalid), 64'h002);
    check("ord_data_b", 64'(req_bus.readdata), 64'h00B);
    next_cycle();
    avm_bus.readdata = 32'h0000_000C;
    #1;
    check("ord_rdv_c", 64'(req_bus.readdatavalid), 64'h080);
    next_cycle();
    avm_bus.readdatavalid = 1'b0;
    #1;
    check("ord_idle_rdv", 64'(req_bus.readdatavalid), 64'd0);
    check("ord_err_clear", 64'(err), 64'd0);

    // Unexpected read data with an empty tag FIFO.
    next_cycle();
    avm_bus.readdatavalid = 1'b1;
    #1;
    check("err_no_strobe", 64'(req_bus.readdatavalid), 64'd0);
    next_cycle();
    avm_bus.readdatavalid = 1'b0;
    #1;
    check("err_set", 64'(err), 64'd1);
    next_cycle();
    check("err_sticky", 64'(err), 64'd1);

    // Reset with a read outstanding flushes the FIFO; late data is flagged.
    req_bus.read[0] = 1'b1;
    #1;
    check("flush_issue", 64'(avm_bus.address), 64'd100);
    next_cycle();
    req_bus.read[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("flush_err_cleared", 64'(err), 64'd0);
    check("flush_wait", 64'(req_bus.waitrequest), 64'(ALL_WAIT));
    next_cycle();
    rst = 1'b0;
    avm_bus.readdatavalid = 1'b1;
    #1;
    check("flush_no_strobe", 64'(req_bus.readdatavalid), 64'd0);
    next_cycle();
    avm_bus.readdatavalid = 1'b0;
    #1;
    check("flush_err_set", 64'(err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
